// File: rtl/anita3_trigger_issuer.sv
// ANITA-3 trigger issuer: turns RF / external request edges into single-cycle
// trigger pulses, waits for the downstream holdoff handshake, and keeps
// issued / rejected / deadtime statistics.
module anita3_trigger_issuer #(
    parameter int DATA_W = 16
) (
    input  logic              clk250_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              rf_req_i,
    input  logic              ext_req_i,
    input  logic              holdoff_i,
    input  logic              clear_i,
    output logic              trig_o,
    output logic              trig_src_o,
    output logic [DATA_W-1:0] trig_count_o,
    output logic [DATA_W-1:0] reject_count_o,
    output logic [DATA_W-1:0] deadtime_o,
    output logic              holdoff_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRE  = 2'd1,
        ARM   = 2'd2,
        BLOCK = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [1:0] arm_cnt;

    // previous request values for edge detection
    logic rf_req_p0;
    logic ext_req_p0;

    logic rf_edge;
    logic ext_edge;
    logic any_edge;
    logic issue;
    logic reject;
    logic arm_timeout;

    // counter increment that sticks at all-ones
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // counter increment that rolls over to zero
    function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v);
        return v + CNT_ONE;
    endfunction

    assign rf_edge  = rf_req_i & ~rf_req_p0;
    assign ext_edge = ext_req_i & ~ext_req_p0;
    assign any_edge = rf_edge | ext_edge;

    // an edge is only served from IDLE with no holdoff; elsewhere it is a reject,
    // and a simultaneous RF+ext pair counts as a single request
    assign issue       = (state == IDLE) && !holdoff_i && enable_i && any_edge;
    assign reject      = any_edge && ((state != IDLE) || holdoff_i);
    assign arm_timeout = (state == ARM) && !holdoff_i && (arm_cnt == 2'd3);

    // edge-detect registers come out of reset high so a level already present is not an edge
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            rf_req_p0  <= 1'b1;
            ext_req_p0 <= 1'b1;
        end else begin
            rf_req_p0  <= rf_req_i;
            ext_req_p0 <= ext_req_i;
        end
    end

    // trigger handshake FSM with registered pulse and source outputs
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            trig_o     <= 1'b0;
            trig_src_o <= 1'b0;
            arm_cnt    <= 2'd0;
        end else begin
            trig_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (holdoff_i) begin
                        state <= BLOCK;
                    end else if (issue) begin
                        state      <= FIRE;
                        trig_o     <= 1'b1;
                        trig_src_o <= ext_edge;
                    end
                end
                FIRE: begin
                    state   <= ARM;
                    arm_cnt <= 2'd0;
                end
                ARM: begin
                    if (holdoff_i) begin
                        state <= BLOCK;
                    end else if (arm_timeout) begin
                        state <= IDLE;
                    end else begin
                        arm_cnt <= arm_cnt + 2'd1;
                    end
                end
                BLOCK: begin
                    if (!holdoff_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // statistics counters and sticky holdoff error; clear beats any same-cycle update
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            trig_count_o   <= '0;
            reject_count_o <= '0;
            deadtime_o     <= '0;
            holdoff_err_o  <= 1'b0;
        end else if (clear_i) begin
            trig_count_o   <= '0;
            reject_count_o <= '0;
            deadtime_o     <= '0;
            holdoff_err_o  <= 1'b0;
        end else begin
            if (issue) begin
                trig_count_o <= wrap_inc(trig_count_o);
            end
            if (reject) begin
                reject_count_o <= sat_inc(reject_count_o);
            end
            if (holdoff_i) begin
                deadtime_o <= sat_inc(deadtime_o);
            end
            if (arm_timeout) begin
                holdoff_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_anita3_trigger_issuer.sv
// Scoreboard bench for anita3_trigger_issuer: a behavioural model queues the
// expected trigger pulses, a monitor pops them whenever trig_o is seen high.
module tb_anita3_trigger_issuer;

    logic        clk250_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        rf_req_i;
    logic        ext_req_i;
    logic        holdoff_i;
    logic        clear_i;
    logic        trig_o;
    logic        trig_src_o;
    logic [15:0] trig_count_o;
    logic [15:0] reject_count_o;
    logic [15:0] deadtime_o;
    logic        holdoff_err_o;

    anita3_trigger_issuer dut (
        .clk250_i       (clk250_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .rf_req_i       (rf_req_i),
        .ext_req_i      (ext_req_i),
        .holdoff_i      (holdoff_i),
        .clear_i        (clear_i),
        .trig_o         (trig_o),
        .trig_src_o     (trig_src_o),
        .trig_count_o   (trig_count_o),
        .reject_count_o (reject_count_o),
        .deadtime_o     (deadtime_o),
        .holdoff_err_o  (holdoff_err_o)
    );

    always #2 clk250_i = ~clk250_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic src;
        int   cnt;
    } trig_t;

    trig_t exp_q[$];

    // behavioural model: request edges, a busy window after each trigger, statistics
    logic m_rf_prev, m_ext_prev;
    bit   m_fire, m_armed, m_blocked;
    int   m_arm_cycles;
    logic m_src, m_err;
    int   m_tc, m_rej, m_dead;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_rf_prev    = 1'b1;
        m_ext_prev   = 1'b1;
        m_fire       = 0;
        m_armed      = 0;
        m_blocked    = 0;
        m_arm_cycles = 0;
        m_src        = 1'b0;
        m_err        = 1'b0;
        m_tc         = 0;
        m_rej        = 0;
        m_dead       = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic en, input logic rf, input logic ext,
                              input logic ho, input logic clr);
        logic rfe, exe, anye, idle, issue;
        rfe   = rf & ~m_rf_prev;
        exe   = ext & ~m_ext_prev;
        anye  = rfe | exe;
        idle  = !(m_fire || m_armed || m_blocked);
        issue = idle && !ho && en && anye;
        if (anye && (!idle || ho)) m_rej = (m_rej + 1 > 65535) ? 65535 : m_rej + 1;
        if (ho) m_dead = (m_dead + 1 > 65535) ? 65535 : m_dead + 1;
        if (issue) begin
            m_tc  = (m_tc + 1) % 65536;
            m_src = exe;
        end
        if (m_fire) begin
            m_fire       = 0;
            m_armed      = 1;
            m_arm_cycles = 0;
        end else if (m_armed) begin
            if (ho) begin
                m_armed   = 0;
                m_blocked = 1;
            end else begin
                m_arm_cycles++;
                if (m_arm_cycles == 4) begin
                    m_armed = 0;
                    m_err   = 1'b1;
                end
            end
        end else if (m_blocked) begin
            if (!ho) m_blocked = 0;
        end else if (ho) begin
            m_blocked = 1;
        end else if (issue) begin
            m_fire = 1;
        end
        if (clr) begin
            m_tc   = 0;
            m_rej  = 0;
            m_dead = 0;
            m_err  = 1'b0;
        end
        if (issue) exp_q.push_back('{src: exe, cnt: m_tc});
        m_rf_prev  = rf;
        m_ext_prev = ext;
    endtask

    task automatic compare_all();
        check("trig_o", {31'd0, trig_o}, {31'd0, logic'(m_fire)});
        check("trig_src", {31'd0, trig_src_o}, {31'd0, m_src});
        check("trig_count", {16'd0, trig_count_o}, m_tc);
        check("reject_count", {16'd0, reject_count_o}, m_rej);
        check("deadtime", {16'd0, deadtime_o}, m_dead);
        check("holdoff_err", {31'd0, holdoff_err_o}, {31'd0, m_err});
    endtask

    // one clock: drive inputs, advance the model, then compare after the edge
    task automatic cyc(input logic en, input logic rf, input logic ext,
                       input logic ho, input logic clr);
        enable_i  = en;
        rf_req_i  = rf;
        ext_req_i = ext;
        holdoff_i = ho;
        clear_i   = clr;
        model_step(en, rf, ext, ho, clr);
        @(posedge clk250_i);
        #1;
        compare_all();
    endtask

    task automatic settle();
        repeat (8) cyc(1'b1, rf_req_i, ext_req_i, 1'b0, 1'b0);
        check("pending_trig", exp_q.size(), 0);
    endtask

    // monitor: every observed pulse must match the oldest expected trigger
    always @(negedge clk250_i) begin
        if (rst_i === 1'b0 && trig_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_trig actual trig_o=1 required trig_o=0");
            end else begin
                trig_t e;
                e = exp_q.pop_front();
                check("mon_trig_src", {31'd0, trig_src_o}, {31'd0, e.src});
                check("mon_trig_count", {16'd0, trig_count_o}, e.cnt);
            end
        end
    end

    initial begin
        rst_i     = 1'b1;
        enable_i  = 1'b0;
        rf_req_i  = 1'b0;
        ext_req_i = 1'b0;
        holdoff_i = 1'b0;
        clear_i   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk250_i);
        #1;
        compare_all();
        rst_i = 1'b0;

        // single RF trigger with a 32-clock holdoff
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fire_pulse", {31'd0, trig_o}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fire_one_cycle", {31'd0, trig_o}, 32'd0);
        repeat (32) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dir_src_rf", {31'd0, trig_src_o}, 32'd0);
        check("dir_count1", {16'd0, trig_count_o}, 32'd1);
        check("dir_dead32", {16'd0, deadtime_o}, 32'd32);
        settle();

        // simultaneous RF + ext: one trigger, ext source, no reject
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("both_src_ext", {31'd0, trig_src_o}, 32'd1);
        check("both_count1", {16'd0, trig_count_o}, 32'd1);
        check("both_reject0", {16'd0, reject_count_o}, 32'd0);
        settle();

        // three rejected edges during holdoff, then a fresh trigger
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2 == 0), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rej_count1", {16'd0, trig_count_o}, 32'd1);
        check("rej_reject3", {16'd0, reject_count_o}, 32'd3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rej_count2", {16'd0, trig_count_o}, 32'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();

        // holdoff never acknowledges: error after four ARM cycles, then clear
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("err_not_yet", {31'd0, holdoff_err_o}, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("err_set", {31'd0, holdoff_err_o}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_cleared", {31'd0, holdoff_err_o}, 32'd0);
        check("clr_count", {16'd0, trig_count_o}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_after_err", {31'd0, trig_o}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        settle();

        // trig_count wraps from 0xFFFF to 0
        force dut.trig_count_o = 16'hFFFF;
        #1;
        release dut.trig_count_o;
        m_tc = 65535;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_zero", {16'd0, trig_count_o}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();

        // randomized traffic
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            logic en, rf, ext, ho, clr;
            en  = ($urandom_range(7) != 0);
            rf  = ($urandom_range(2) == 0) ? ~rf_req_i : rf_req_i;
            ext = ($urandom_range(5) == 0) ? ~ext_req_i : ext_req_i;
            ho  = ($urandom_range(3) == 0) ? ~holdoff_i : holdoff_i;
            clr = ($urandom_range(63) == 0);
            cyc(en, rf, ext, ho, clr);
        end
        settle();

        // reject_count and deadtime saturate at 0xFFFF
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) cyc(1'b1, (i % 2 == 0), (i % 2 == 1), 1'b1, 1'b0);
        check("rej_sat", {16'd0, reject_count_o}, 32'hFFFF);
        check("dead_sat", {16'd0, deadtime_o}, 32'hFFFF);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rej_sat_hold", {16'd0, reject_count_o}, 32'hFFFF);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();

        // reset during FIRE with rf_req held high
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_fire", {31'd0, trig_o}, 32'd1);
        rst_i = 1'b1;
        model_reset();
        #1;
        check("rst_trig_o", {31'd0, trig_o}, 32'd0);
        check("rst_src", {31'd0, trig_src_o}, 32'd0);
        check("rst_tc", {16'd0, trig_count_o}, 32'd0);
        check("rst_rej", {16'd0, reject_count_o}, 32'd0);
        check("rst_dead", {16'd0, deadtime_o}, 32'd0);
        check("rst_err", {31'd0, holdoff_err_o}, 32'd0);
        repeat (2) @(posedge clk250_i);
        #1;
        rst_i = 1'b0;
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("no_trig_after_rst", {16'd0, trig_count_o}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("trig_after_toggle", {31'd0, trig_o}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
